mc_control_unit: RTL and testbench

Multicycle fetch/decode/execute/writeback controller for the multicycle CPU. It owns the PC, an 8 x 32 register file and the instruction-memory handshake. It sits directly upstream of the ALU: it drives the ALU operands and opcode, then consumes the ALU result and the `change_pc` branch decision to update the register file or the PC.

---
 rtl/mc_cpu_pkg.sv | 55 +++++
 rtl/mc_regfile.sv | 52 +++++
 rtl/mc_control_unit.sv | 165 ++++++++++++++++
 tb/tb_mc_control_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg
// Shared definitions for the multicycle CPU controller: opcode constants,
// controller state encoding, instruction field positions and small decode
// helpers. Imported by mc_regfile and mc_control_unit.
`timescale 1ns/1ps
package mc_cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int INSTR_W  = 32;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;

    // Instruction layout: [31:29] opcode, [28:26] rd, [25:23] rs0,
    // [22:20] rs1, [19:0] signed word offset (branches only).
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 29;
    localparam int RD_HI  = 28;
    localparam int RD_LO  = 26;
    localparam int RS0_HI = 25;
    localparam int RS0_LO = 23;
    localparam int RS1_HI = 22;
    localparam int RS1_LO = 20;
    localparam int OFF_HI = 19;
    localparam int OFF_LO = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_HALT = 3'b001,
        OP_BEQ  = 3'b010,
        OP_BLT  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_AND  = 3'b110,
        OP_OR   = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_t;

    // All register-writing ALU operations have the top opcode bit set.
    function automatic logic is_alu_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_branch(input logic [2:0] op);
        return (op == OP_BEQ) || (op == OP_BLT);
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile
// 8 x 32 register file: two combinational read ports, one synchronous
// write port, asynchronous active-high reset clearing every register.
//
// Configuration macro: MC_CTRL_R0_ZERO_EN
//   defined   -> r0 always reads 0 and writes to r0 are dropped
//   undefined -> r0 is an ordinary register
//
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   raddr0_i / rdata0_o    read port 0
//   raddr1_i / rdata1_o    read port 1
//   we_i, waddr_i, wdata_i write port (written on the rising edge)
`timescale 1ns/1ps
module mc_regfile
    import mc_cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] raddr0_i,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en;

`ifdef MC_CTRL_R0_ZERO_EN
    assign wr_en    = we_i && (waddr_i != '0);
    assign rdata0_o = (raddr0_i == '0) ? '0 : regs_q[raddr0_i];
    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
`else
    assign wr_en    = we_i;
    assign rdata0_o = regs_q[raddr0_i];
    assign rdata1_o = regs_q[raddr1_i];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit
// Multicycle FETCH -> WAIT -> DECODE -> EXEC -> WB controller. Owns the PC,
// the instruction register and the register file, drives an external
// combinational ALU and applies its result / branch decision.
//
// Configuration macro: MC_CTRL_R0_ZERO_EN (handled inside mc_regfile).
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   imem_req, imem_addr           one-cycle fetch request at address PC
//   imem_valid, imem_data         instruction return
//   alu_ip_0, alu_ip_1, alu_opcode ALU operands / opcode (000 outside EXEC)
//   alu_op_0, alu_change_pc       ALU result / branch-taken (used in EXEC only)
//   halted, pc_out                HALT indication, current PC
//
// Fetch handshake: imem_req is a single-cycle pulse issued in FETCH. The
// memory answers with imem_valid high for the cycle in which imem_data holds
// the instruction; only the WAIT state samples it, so a valid seen in the
// FETCH cycle itself or in any later state is ignored.
`timescale 1ns/1ps
module mc_control_unit
    import mc_cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_data,
    output logic [31:0]     alu_ip_0,
    output logic [31:0]     alu_ip_1,
    output logic [2:0]      alu_opcode,
    input  logic [31:0]     alu_op_0,
    input  logic            alu_change_pc,
    output logic            halted,
    output logic [PC_W-1:0] pc_out
);

    ctrl_state_t     state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     alu_out_q, alu_out_d;
    logic            taken_q, taken_d;

    logic [2:0]        ir_op;
    logic [REG_AW-1:0] ir_rd, ir_rs0, ir_rs1;
    logic [PC_W-1:0]   br_off;
    logic [31:0]       rf_rdata0, rf_rdata1;
    logic              rf_we;

    assign ir_op  = ir_q[OPC_HI:OPC_LO];
    assign ir_rd  = ir_q[RD_HI:RD_LO];
    assign ir_rs0 = ir_q[RS0_HI:RS0_LO];
    assign ir_rs1 = ir_q[RS1_HI:RS1_LO];
    // Sign-extend the word offset, then keep PC_W bits so the add wraps
    // modulo the instruction memory size.
    assign br_off = PC_W'(signed'(ir_q[OFF_HI:OFF_LO]));

    mc_regfile u_regfile (
        .clk_i    (clk),
        .rst_i    (rst),
        .raddr0_i (ir_rs0),
        .raddr1_i (ir_rs1),
        .rdata0_o (rf_rdata0),
        .rdata1_o (rf_rdata1),
        .we_i     (rf_we),
        .waddr_i  (ir_rd),
        .wdata_i  (alu_out_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            taken_q   <= taken_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_out_d  = alu_out_q;
        taken_d    = taken_q;
        rf_we      = 1'b0;
        alu_opcode = OP_NOP;

        case (state_q)
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (ir_op == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (ir_op == OP_NOP) begin
                    state_d = ST_WB;
                end else begin
                    // A/B are also the ALU operand drivers, so they are only
                    // reloaded on the way into EXEC; otherwise the operands
                    // keep the values of the last executed instruction.
                    a_d     = rf_rdata0;
                    b_d     = rf_rdata1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_opcode = ir_op;
                alu_out_d  = alu_op_0;
                taken_d    = alu_change_pc;
                state_d    = ST_WB;
            end
            ST_WB: begin
                state_d = ST_FETCH;
                if (is_alu_op(ir_op)) begin
                    rf_we = 1'b1;
                end
                if (is_branch(ir_op) && taken_q) begin
                    pc_d = pc_q + br_off;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Gated with rst so the request stays low while reset is held even
    // though the state register already sits in FETCH.
    assign imem_req  = (state_q == ST_FETCH) && !rst;
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign alu_ip_0  = a_q;
    assign alu_ip_1  = b_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_mc_control_unit.sv
`timescale 1ns/1ps
module tb_mc_control_unit;
  import mc_cpu_pkg::*;

  localparam int PC_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid = 1'b0;
  logic [31:0]     imem_data = 32'd0;
  logic [31:0]     alu_ip_0, alu_ip_1;
  logic [2:0]      alu_opcode;
  logic [31:0]     alu_op_0 = 32'd0;
  logic            alu_change_pc = 1'b0;
  logic            halted;
  logic [PC_W-1:0] pc_out;

  mc_control_unit #(.PC_W(PC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .alu_ip_0      (alu_ip_0),
    .alu_ip_1      (alu_ip_1),
    .alu_opcode    (alu_opcode),
    .alu_op_0      (alu_op_0),
    .alu_change_pc (alu_change_pc),
    .halted        (halted),
    .pc_out        (pc_out)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] instr; logic force_en; logic [31:0] force_val; int waits; } prog_t;
  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } exec_t;
  typedef struct { logic [31:0] res; logic taken; } resp_t;

  prog_t           prog_q[$];
  int              rand_left = 0;
  logic [PC_W-1:0] exp_addr_q[$];
  int              exp_lat_q[$];
  exec_t           exp_exec_q[$];
  resp_t           resp_q[$];

  // architectural model
  logic [31:0]     m_regs[8];
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_halt_pc;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  function automatic logic [31:0] m_read(logic [2:0] r);
`ifdef MC_CTRL_R0_ZERO_EN
    if (r == 3'd0) return 32'd0;
`endif
    return m_regs[r];
  endfunction

  function automatic logic [31:0] alu_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'b100:  return a + b;
      3'b101:  return a - b;
      3'b110:  return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    m_pc = '0;
    m_halt_pc = '0;
    exp_addr_q.delete();
    exp_lat_q.delete();
    exp_exec_q.delete();
    resp_q.delete();
    exp_addr_q.push_back('0);
  endfunction

  // Apply one fetched instruction to the model and queue what the DUT must show.
  function automatic void model_step(logic [31:0] instr, logic force_en, logic [31:0] fv, int waits);
    logic [2:0]         op = instr[31:29];
    logic [2:0]         rd = instr[28:26];
    logic signed [19:0] offs = instr[19:0];
    logic [31:0]        a = m_read(instr[25:23]);
    logic [31:0]        b = m_read(instr[22:20]);
    exec_t              e;
    resp_t              r;
    logic               taken;
    e.op = op; e.a = a; e.b = b;
    case (op)
      3'b000: begin
        m_pc = m_pc + PC_W'(1);
        exp_addr_q.push_back(m_pc);
        exp_lat_q.push_back(4 + waits);
      end
      3'b001: begin
        m_halt_pc = m_pc;
      end
      3'b010, 3'b011: begin
        taken = (op == 3'b010) ? (a == b) : ($signed(a) < $signed(b));
        r.res = $urandom; r.taken = taken;
        exp_exec_q.push_back(e);
        resp_q.push_back(r);
        m_pc = taken ? PC_W'(int'(m_pc) + int'(offs)) : m_pc + PC_W'(1);
        exp_addr_q.push_back(m_pc);
        exp_lat_q.push_back(5 + waits);
      end
      default: begin
        if (force_en) r.res = fv;
        else r.res = ($urandom_range(0, 1) == 1) ? $urandom : alu_ref(op, a, b);
        r.taken = 1'($urandom);
        exp_exec_q.push_back(e);
        resp_q.push_back(r);
        m_regs[rd] = r.res;
        m_pc = m_pc + PC_W'(1);
        exp_addr_q.push_back(m_pc);
        exp_lat_q.push_back(5 + waits);
      end
    endcase
  endfunction

  function automatic logic [31:0] mk(logic [2:0] op, logic [2:0] rd, logic [2:0] rs0, logic [2:0] rs1, int off);
    return {op, rd, rs0, rs1, 20'(off)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [2:0] op = 3'($urandom_range(0, 7));
    int off = int'($urandom_range(0, 40)) - 20;
    if (op == 3'b001) op = 3'b100;
    return {op, 3'($urandom), 3'($urandom), 3'($urandom), 20'(off)};
  endfunction

  function automatic void push_prog(logic [31:0] instr, logic fe, logic [31:0] fv, int waits);
    prog_t p;
    p.instr = instr; p.force_en = fe; p.force_val = fv; p.waits = waits;
    prog_q.push_back(p);
  endfunction

  function automatic void next_instr(output logic [31:0] instr, output int waits);
    prog_t p;
    logic fe = 1'b0;
    logic [31:0] fv = 32'd0;
    waits = int'($urandom_range(0, 3));
    if (prog_q.size() > 0) begin
      p = prog_q.pop_front();
      instr = p.instr; fe = p.force_en; fv = p.force_val;
      if (p.waits >= 0) waits = p.waits;
    end else if (rand_left > 0) begin
      rand_left--;
      instr = rand_instr();
    end else begin
      instr = {3'b001, 29'($urandom)};
    end
    model_step(instr, fe, fv, waits);
  endfunction

  // ---------------- driver: instruction memory ----------------
  logic [31:0] cur_instr;
  int          cur_waits;
  bit          pending = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pending    = 1'b0;
      imem_valid = 1'b1;            // stale return during reset must be ignored
      imem_data  = $urandom;
    end else if (imem_req) begin
      next_instr(cur_instr, cur_waits);
      pending    = 1'b1;
      imem_valid = 1'($urandom_range(0, 1)); // junk in the FETCH cycle
      imem_data  = $urandom;
    end else if (pending) begin
      if (cur_waits == 0) begin
        imem_valid = 1'b1;
        imem_data  = cur_instr;
        pending    = 1'b0;
      end else begin
        imem_valid = 1'b0;
        imem_data  = $urandom;
        cur_waits--;
      end
    end else begin
      imem_valid = 1'($urandom_range(0, 1));
      imem_data  = $urandom;
    end
  end

  // ---------------- driver: ALU stand-in ----------------
  always @(negedge clk) begin
    resp_t r;
    if (!rst && alu_opcode != 3'b000 && resp_q.size() > 0) begin
      r = resp_q.pop_front();
      alu_op_0      = r.res;
      alu_change_pc = r.taken;
    end else begin
      alu_op_0      = $urandom;
      alu_change_pc = 1'($urandom);
    end
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          prev_cyc = 0;
  bit          have_prev = 1'b0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;

  always @(negedge clk) begin
    logic [PC_W-1:0] ea;
    exec_t e;
    if (rst) begin
      have_prev = 1'b0;
      cyc       = 0;
      last_a    = 32'd0;
      last_b    = 32'd0;
    end else begin
      cyc++;
      if (imem_req) begin
        if (exp_addr_q.size() == 0) begin
          fail("unexpected imem_req");
        end else begin
          ea = exp_addr_q.pop_front();
          check("imem_addr", 32'(imem_addr), 32'(ea));
          check("pc_out at fetch", 32'(pc_out), 32'(ea));
        end
        if (!have_prev) begin
          check("first req cycle", cyc, 1);
        end else if (exp_lat_q.size() == 0) begin
          fail("latency queue empty");
        end else begin
          check("latency", cyc - prev_cyc, exp_lat_q.pop_front());
        end
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
      if (alu_opcode != 3'b000) begin
        if (exp_exec_q.size() == 0) begin
          fail("unexpected exec");
        end else begin
          e = exp_exec_q.pop_front();
          check("alu_opcode", 32'(alu_opcode), 32'(e.op));
          check("alu_ip_0", alu_ip_0, e.a);
          check("alu_ip_1", alu_ip_1, e.b);
          last_a = e.a;
          last_b = e.b;
        end
      end else begin
        check("alu_ip_0 hold", alu_ip_0, last_a);
        check("alu_ip_1 hold", alu_ip_1, last_b);
      end
    end
  end

  // ---------------- sequencing tasks ----------------
  task automatic apply_reset(int n);
    rst = 1'b1;
    model_reset();
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst imem_req", 32'(imem_req), 32'd0);
    check("rst alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst alu_ip_0", alu_ip_0, 32'd0);
    check("rst alu_ip_1", alu_ip_1, 32'd0);
    check("rst halted", 32'(halted), 32'd0);
    check("rst pc_out", 32'(pc_out), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      fail("halt timeout");
    end else begin
      check("halt pc_out", 32'(pc_out), 32'(m_halt_pc));
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check("halted held", 32'(halted), 32'd1);
        check("no req in halt", 32'(imem_req), 32'd0);
      end
      check("halt pc_out after", 32'(pc_out), 32'(m_halt_pc));
      check("exec queue drained", exp_exec_q.size(), 0);
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int n;

    // Directed: arithmetic, operand routing, r0 behaviour, branches.
    prog_q.delete();
    push_prog(mk(OP_ADD, 3'd1, 3'd0, 3'd0, 0), 1'b1, 32'd0, 0);  // pc0
    push_prog(mk(OP_ADD, 3'd2, 3'd0, 3'd0, 0), 1'b1, 32'd7, 0);  // pc1 r2=7
    push_prog(mk(OP_ADD, 3'd3, 3'd0, 3'd0, 0), 1'b1, 32'd5, 1);  // pc2 r3=5
    push_prog(mk(OP_SUB, 3'd4, 3'd2, 3'd3, 0), 1'b1, 32'd2, 3);  // pc3 sub, 3 waits
    push_prog(mk(OP_OR,  3'd6, 3'd4, 3'd0, 0), 1'b0, 32'd0, 0);  // pc4 reads r4
    push_prog(mk(OP_ADD, 3'd0, 3'd0, 3'd0, 0), 1'b1, 32'h1234, 0); // pc5 write r0
    push_prog(mk(OP_OR,  3'd7, 3'd0, 3'd0, 0), 1'b0, 32'd0, 0);  // pc6 reads r0
    push_prog(mk(OP_NOP, 3'd0, 3'd0, 3'd0, 0), 1'b0, 32'd0, 0);  // pc7
    push_prog(mk(OP_NOP, 3'd0, 3'd0, 3'd0, 0), 1'b0, 32'd0, 2);  // pc8
    push_prog(mk(OP_NOP, 3'd0, 3'd0, 3'd0, 0), 1'b0, 32'd0, 0);  // pc9
    push_prog(mk(OP_BEQ, 3'd0, 3'd2, 3'd2, -3), 1'b0, 32'd0, 0); // pc10 -> 7
    push_prog(mk(OP_BLT, 3'd0, 3'd2, 3'd3, 5), 1'b0, 32'd0, 0);  // pc7 -> 8
    push_prog(mk(OP_HALT, 3'd0, 3'd0, 3'd0, 0), 1'b0, 32'd0, 0); // pc8
    rand_left = 0;
    apply_reset(3);
    wait_halt(300);
    check("directed halt pc", 32'(m_halt_pc), 32'd8);

    // Random program.
    prog_q.delete();
    rand_left = 80;
    apply_reset(2);
    wait_halt(2000);

    // Halt at PC=4, then reset out of HALT.
    prog_q.delete();
    rand_left = 0;
    for (int i = 0; i < 4; i++) push_prog(mk(OP_NOP, 3'd0, 3'd0, 3'd0, 0), 1'b0, 32'd0, -1);
    push_prog(mk(OP_HALT, 3'd0, 3'd0, 3'd0, 0), 1'b0, 32'd0, 0);
    apply_reset(2);
    wait_halt(200);
    check("halt at 4", 32'(pc_out), 32'd4);

    // Reset during EXEC of add r5: no write, fresh FETCH from PC 0.
    prog_q.delete();
    push_prog(mk(OP_ADD, 3'd5, 3'd1, 3'd2, 0), 1'b1, 32'hAAAA5555, 0);
    apply_reset(2);
    n = 0;
    @(negedge clk);
    while (alu_opcode == 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (alu_opcode == 3'b000) fail("exec timeout");
    #1;
    prog_q.delete();
    push_prog(mk(OP_OR, 3'd1, 3'd5, 3'd5, 0), 1'b0, 32'd0, 0);   // r5 must read 0
    push_prog(mk(OP_HALT, 3'd0, 3'd0, 3'd0, 0), 1'b0, 32'd0, 0);
    apply_reset(2);
    wait_halt(200);

    // Second random program with a fresh reset.
    prog_q.delete();
    rand_left = 60;
    apply_reset(1);
    wait_halt(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
